// File: rtl/bmp_pkg.sv
// Shared BMP constants, FSM state encoding and row-padding helper.
// Imported by the header ROM and the stream writer.
package bmp_pkg;

   localparam int BMP_HDR_SIZE = 54;
   localparam int BMP_BPP      = 24;
   localparam int BMP_PPM      = 2835;
   localparam int BMP_DIB_SIZE = 40;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PIXEL,
      S_PAD,
      S_DONE
   } bmp_state_t;

   // Zero bytes needed to take a 24-bit row up to a 4-byte boundary.
   function automatic int bmp_row_pad(input int width);
      return (4 - ((3 * width) % 4)) % 4;
   endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational 54-byte BMP header table for a fixed image size.
// Ports: idx (header byte index 0..53), data (header byte, 0 beyond 53).
module bmp_header_rom
   import bmp_pkg::*;
#(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 32
) (
   input  logic [5:0] idx,
   output logic [7:0] data
);

   localparam int ROW_BYTES = 3 * IMG_WIDTH;
   localparam int STRIDE    = ROW_BYTES + bmp_row_pad(IMG_WIDTH);

   localparam logic [31:0] IMG_SIZE  = 32'(IMG_HEIGHT * STRIDE);
   localparam logic [31:0] FILE_SIZE = 32'(BMP_HDR_SIZE) + IMG_SIZE;
   localparam logic [31:0] W32       = 32'(IMG_WIDTH);
   localparam logic [31:0] H32       = 32'(IMG_HEIGHT);
   localparam logic [31:0] PLN_BPP   = {16'(BMP_BPP), 16'd1};

   logic [5:0]  off;
   logic [31:0] fld;

   // Bytes 2..53 form 13 little-endian words starting at offset 2;
   // planes (26-27) and bpp (28-29) share one word.
   always_comb begin
      off = idx - 6'd2;
      fld = '0;
      case (off[5:2])
         4'd0:    fld = FILE_SIZE;
         4'd2:    fld = 32'(BMP_HDR_SIZE);
         4'd3:    fld = 32'(BMP_DIB_SIZE);
         4'd4:    fld = W32;
         4'd5:    fld = H32;
         4'd6:    fld = PLN_BPP;
         4'd8:    fld = IMG_SIZE;
         4'd9:    fld = 32'(BMP_PPM);
         4'd10:   fld = 32'(BMP_PPM);
         default: fld = '0;
      endcase
      data = fld[{off[1:0], 3'b000} +: 8];
      if (idx == 6'd0)
         data = 8'h42;
      else if (idx == 6'd1)
         data = 8'h4D;
      else if (idx >= 6'(BMP_HDR_SIZE))
         data = 8'h00;
   end

endmodule

// File: rtl/bmp_stream_writer.sv
// Frames FWFT grayscale pixels into a 24-bit BMP byte stream.
// Ports: start pulse, input FIFO (in_*), output FIFO (out_*), busy/done.
module bmp_stream_writer
   import bmp_pkg::*;
#(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 32,
   parameter int DWIDTH     = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DWIDTH-1:0] in_dout,
   input  logic              in_empty,
   output logic              in_rd_en,
   output logic [7:0]        out_din,
   input  logic              out_full,
   output logic              out_wr_en,
   output logic              busy,
   output logic              done
);

   localparam int PAD   = bmp_row_pad(IMG_WIDTH);
   localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [5:0]       LAST_HDR = 6'(BMP_HDR_SIZE - 1);
   localparam logic [1:0]       LAST_PAD = 2'(PAD - 1);

   bmp_state_t       state, state_n;
   logic [5:0]       hidx, hidx_n;
   logic [COL_W-1:0] col, col_n;
   logic [ROW_W-1:0] row, row_n;
   logic [1:0]       bidx, bidx_n;
   logic [1:0]       pidx, pidx_n;
   logic [7:0]       pix_reg, pix_n;
   logic [7:0]       hdr_byte;
   logic [7:0]       pix_in;
   logic             eor;

   assign pix_in = 8'(in_dout);

   bmp_header_rom #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT)
   ) u_hdr (
      .idx  (hidx),
      .data (hdr_byte)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         hidx    <= '0;
         col     <= '0;
         row     <= '0;
         bidx    <= '0;
         pidx    <= '0;
         pix_reg <= '0;
      end else begin
         state   <= state_n;
         hidx    <= hidx_n;
         col     <= col_n;
         row     <= row_n;
         bidx    <= bidx_n;
         pidx    <= pidx_n;
         pix_reg <= pix_n;
      end
   end

   always_comb begin
      state_n   = state;
      hidx_n    = hidx;
      col_n     = col;
      row_n     = row;
      bidx_n    = bidx;
      pidx_n    = pidx;
      pix_n     = pix_reg;
      out_din   = '0;
      out_wr_en = 1'b0;
      in_rd_en  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      eor       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_HEADER;
               hidx_n  = '0;
               col_n   = '0;
               row_n   = '0;
               bidx_n  = '0;
               pidx_n  = '0;
            end
         end
         S_HEADER: begin
            busy      = 1'b1;
            out_din   = hdr_byte;
            out_wr_en = !out_full;
            if (out_wr_en) begin
               if (hidx == LAST_HDR)
                  state_n = S_PIXEL;
               else
                  hidx_n = hidx + 6'd1;
            end
         end
         S_PIXEL: begin
            busy = 1'b1;
            if (bidx == 2'd0) begin
               // Pop only together with the push of the first copy.
               out_wr_en = !out_full && !in_empty;
               in_rd_en  = out_wr_en;
               out_din   = pix_in;
               if (out_wr_en) begin
                  pix_n  = pix_in;
                  bidx_n = 2'd1;
               end
            end else begin
               out_din   = pix_reg;
               out_wr_en = !out_full;
               if (out_wr_en) begin
                  if (bidx == 2'd2) begin
                     bidx_n = 2'd0;
                     if (col == LAST_COL) begin
                        col_n = '0;
                        if (PAD > 0) begin
                           state_n = S_PAD;
                           pidx_n  = '0;
                        end else begin
                           eor = 1'b1;
                        end
                     end else begin
                        col_n = col + 1'b1;
                     end
                  end else begin
                     bidx_n = bidx + 2'd1;
                  end
               end
            end
         end
         S_PAD: begin
            busy      = 1'b1;
            out_wr_en = !out_full;
            if (out_wr_en) begin
               if (pidx == LAST_PAD)
                  eor = 1'b1;
               else
                  pidx_n = pidx + 2'd1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      if (eor) begin
         if (row == LAST_ROW) begin
            state_n = S_DONE;
         end else begin
            row_n   = row + 1'b1;
            col_n   = '0;
            state_n = S_PIXEL;
         end
      end
   end

endmodule
